// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared NoC definitions: flit width, flit type codes, the
//               port-requester FSM state encoding and flit-type helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Flit layout: type in the top two bits, 32-bit payload below
    localparam int FLIT_W = 34;

    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_HEAD   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2
    } req_state_t;

    // A flit that may legally open a packet
    function automatic logic is_start(input logic [1:0] t);
        return (t == FT_HEAD) || (t == FT_SINGLE);
    endfunction

    // A flit that closes a packet
    function automatic logic is_end(input logic [1:0] t);
        return (t == FT_TAIL) || (t == FT_SINGLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : flit_fifo
// Description : Synchronous FIFO with show-ahead head (dout is the oldest
//               entry whenever !empty). Pointers carry one extra wrap bit so
//               full and empty are distinguished without a counter.
// Revision    : 1.0 - initial release
// ============================================================================
module flit_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Guard both ports so a stray request can never corrupt the pointers
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read/write pointers wrap naturally modulo 2*DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/port_requester.sv
`default_nettype none
// ============================================================================
// Module      : port_requester
// Description : Input-port requester. Buffers flits, requests the output
//               port arbiter on a packet head, forwards one flit per granted
//               cycle until the packet tail, and discards flits that arrive
//               without a preceding head.
// Revision    : 1.0 - initial release
// ============================================================================
module port_requester
    import noc_pkg::*;
#(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic              req,
    input  logic              gnt,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic              drop_err
);

    req_state_t        r_state;
    logic              r_req;
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_flit;
    logic              r_drop_err;

    logic [FLIT_W-1:0] w_head;
    logic [1:0]        w_head_type;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_active;

    assign in_ready    = !w_full;
    assign w_push      = in_valid && !w_full;
    assign w_head_type = w_head[FLIT_W-1 -: 2];
    assign w_active    = (r_state == ST_REQ) || (r_state == ST_SEND);

    // Pop either to forward a granted flit or to discard an orphan body/tail
    assign w_pop = !w_empty &&
                   ((r_state == ST_IDLE && !is_start(w_head_type)) ||
                    (w_active && gnt));

    flit_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (in_flit),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Packet FSM with registered req/out_valid/out_flit/drop_err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_drop_err  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_drop_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        if (is_start(w_head_type)) begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                        end else begin
                            r_drop_err <= 1'b1;
                        end
                    end
                end
                ST_REQ, ST_SEND: begin
                    if (gnt && !w_empty) begin
                        r_out_valid <= 1'b1;
                        r_out_flit  <= w_head;
                        if (is_end(w_head_type)) begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                        end else begin
                            r_state <= ST_SEND;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign req       = r_req;
    assign out_valid = r_out_valid;
    assign out_flit  = r_out_flit;
    assign drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_port_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_requester
// Description : Self-checking bench for port_requester: directed packet
//               scenarios plus random traffic against a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_requester;

    localparam int FW    = 34;
    localparam int DEPTH = 4;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [FW-1:0] in_flit = '0;
    logic          in_ready;
    logic          req;
    logic          gnt = 1'b0;
    logic          out_valid;
    logic [FW-1:0] out_flit;
    logic          drop_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: buffered flits and whether a packet is open
    logic [FW-1:0] mq[$];
    bit            m_open;
    logic [FW-1:0] m_last_out;
    bit            e_ov;
    bit            e_drop;

    port_requester #(.FLIT_W(FW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] p);
        return {t, p};
    endfunction

    // Model one clock edge from the packet-protocol rules
    task automatic model_edge(input bit v, input logic [FW-1:0] f, input bit g);
        bit            accept;
        logic [FW-1:0] x;
        accept = v && (mq.size() < DEPTH);
        e_ov   = 0;
        e_drop = 0;
        if (!m_open) begin
            if (mq.size() > 0) begin
                case (mq[0][FW-1 -: 2])
                    T_HEAD, T_SINGLE: m_open = 1;
                    default: begin
                        x = mq.pop_front();
                        e_drop = 1;
                    end
                endcase
            end
        end else if (g && mq.size() > 0) begin
            x = mq.pop_front();
            e_ov = 1;
            m_last_out = x;
            if (x[FW-1 -: 2] == T_TAIL || x[FW-1 -: 2] == T_SINGLE) m_open = 0;
        end
        if (accept) mq.push_back(f);
    endtask

    // One cycle: called at a negedge, drives inputs, checks after the edge
    task automatic step(input bit v, input logic [FW-1:0] f, input bit g);
        in_valid = v;
        in_flit  = f;
        gnt      = g;
        #1;
        chk_val("in_ready", in_ready, (mq.size() < DEPTH));
        @(posedge clk);
        model_edge(v, f, g);
        @(negedge clk);
        chk_val("req", req, m_open);
        chk_val("out_valid", out_valid, e_ov);
        chk_val("out_flit", out_flit, m_last_out);
        chk_val("drop_err", drop_err, e_drop);
    endtask

    task automatic idle(input int n, input bit g);
        for (int i = 0; i < n; i++) step(0, '0, g);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately
    task automatic do_reset();
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        gnt = 1'b0;
        #1;
        chk_val("rst_req", req, 0);
        chk_val("rst_out_valid", out_valid, 0);
        chk_val("rst_out_flit", out_flit, 0);
        chk_val("rst_drop_err", drop_err, 0);
        chk_val("rst_in_ready", in_ready, 1);
        mq.delete();
        m_open = 0;
        m_last_out = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m_open = 0;
        m_last_out = '0;
        @(negedge clk);
        do_reset();

        // Single-flit packet, grant from cycle 3
        step(1, 34'h3_0000_00AA, 0);
        step(0, '0, 0);
        chk_val("single_req_up", req, 1);
        step(0, '0, 1);
        chk_val("single_flit", out_flit, 34'h3_0000_00AA);
        chk_val("single_req_down", req, 0);
        idle(2, 1);

        // Four-flit packet, continuous grant
        step(1, mk(T_HEAD, 1), 1);
        step(1, mk(T_BODY, 2), 1);
        step(1, mk(T_BODY, 3), 1);
        step(1, mk(T_TAIL, 4), 1);
        idle(4, 1);

        // Same packet, toggling grant
        step(1, mk(T_HEAD, 1), 1);
        step(1, mk(T_BODY, 2), 0);
        step(1, mk(T_BODY, 3), 1);
        step(1, mk(T_TAIL, 4), 0);
        for (int i = 0; i < 10; i++) step(0, '0, (i % 2) == 0);

        // Fill the FIFO with no grant; fifth flit must be refused
        step(1, mk(T_HEAD, 32'h10), 0);
        step(1, mk(T_BODY, 32'h11), 0);
        step(1, mk(T_BODY, 32'h12), 0);
        step(1, mk(T_TAIL, 32'h13), 0);
        #1;
        chk_val("full_ready", in_ready, 0);
        step(1, mk(T_SINGLE, 32'h14), 0);
        step(0, '0, 1);
        #1;
        chk_val("ready_back", in_ready, 1);
        idle(5, 1);

        // Orphan body flit in IDLE is dropped
        step(1, mk(T_BODY, 32'hBAD), 0);
        step(0, '0, 0);
        chk_val("orphan_drop", drop_err, 1);
        idle(2, 0);
        chk_val("orphan_req", req, 0);

        // Reset in mid-packet after two flits sent
        step(1, mk(T_HEAD, 1), 0);
        step(1, mk(T_BODY, 2), 0);
        step(1, mk(T_BODY, 3), 1);
        step(1, mk(T_TAIL, 4), 1);
        do_reset();
        step(1, mk(T_SINGLE, 32'h55), 0);
        idle(1, 0);
        step(0, '0, 1);
        chk_val("post_rst_flit", out_flit, mk(T_SINGLE, 32'h55));
        idle(2, 0);

        // Random traffic, mostly well-formed packets with some orphans
        for (int i = 0; i < 600; i++) begin
            logic [1:0] t;
            t = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 9) < 6), mk(t, $urandom), ($urandom_range(0, 1) == 1));
        end
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 1) == 1), mk(2'($urandom_range(0, 3)), $urandom), 1);
        end
        idle(10, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/port_requester.md
PORT_REQUESTER -- requirements
Module: port_requester

Interface
REQ-001 Parameter FLIT_W SHALL default to 34 and sets the flit width: type in [33:32], payload in [31:0].
REQ-002 Parameter DEPTH SHALL default to 4 and sets the flit FIFO depth; it SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  an upstream flit is offered this cycle.
REQ-006 in_flit  input  FLIT_W  the upstream flit.
REQ-007 in_ready  output  1  the FIFO accepts a flit this cycle.
REQ-008 req  output  1  request to the output-port arbiter, registered.
REQ-009 gnt  input  1  grant from the arbiter for this port.
REQ-010 out_valid  output  1  out_flit is valid this cycle, registered.
REQ-011 out_flit  output  FLIT_W  flit forwarded through the crossbar, registered.
REQ-012 drop_err  output  1  one-cycle pulse when a malformed flit is discarded.

Function
REQ-013 Flit type codes SHALL be: 01 head, 00 body, 10 tail, 11 single (head and tail).
REQ-014 in_ready SHALL equal !full, independent of any pop in the same cycle; a push SHALL occur on a rising edge when in_valid && in_ready.
REQ-015 A pushed flit SHALL be visible at the FIFO head from the following cycle, and FIFO order SHALL be strictly preserved.
REQ-016 The FSM SHALL have three states: IDLE, REQ and SEND; req SHALL be 1 exactly when state != IDLE.
REQ-017 In IDLE, when the FIFO is non-empty and the head type is head or single, the FSM SHALL move to REQ at the next edge. A flit written at edge k therefore gives req=1 after edge k+1.
REQ-018 In IDLE, when the FIFO is non-empty and the head type is body or tail, that flit SHALL be popped and discarded, drop_err SHALL pulse for one cycle, and the FSM SHALL stay in IDLE.
REQ-019 In REQ or SEND, on an edge where gnt && !empty, one flit SHALL be popped, out_flit SHALL take the head flit, and out_valid SHALL be 1 in the following cycle.
REQ-020 On any edge without a pop, out_valid SHALL be 0 and out_flit SHALL hold its previous value.
REQ-021 If the popped flit is a tail or single, the FSM SHALL return to IDLE, and req SHALL be 0 in the cycle in which that flit's out_valid is 1.
REQ-022 If the popped flit is a head or body, the FSM SHALL go to (or stay in) SEND.
REQ-023 In REQ or SEND, gnt=0 or an empty FIFO SHALL stall the FSM in place with req held at 1; a packet SHALL never be abandoned without reset.
REQ-024 gnt SHALL be ignored in IDLE.
REQ-025 Throughput SHALL be one flit per cycle under continuous gnt with a non-empty FIFO.
REQ-026 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH, with full/empty decided by an extra pointer bit or an occupancy counter.

Reset
REQ-028 While rst=1, the outputs SHALL immediately be: req=0, out_valid=0, out_flit=0, drop_err=0, in_ready=1.
REQ-029 While rst=1, the FSM SHALL be in IDLE and the FIFO SHALL be empty.
REQ-030 A reset in mid-packet SHALL discard all buffered flits; after rst falls, operation SHALL restart with the next pushed head.

Structure
REQ-031 The shared package noc_pkg SHALL hold FLIT_W, the flit type codes, and the FSM state encoding.
REQ-032 The FIFO SHALL be a sub-module named flit_fifo (ports: clk, rst, push, din, pop, dout, full, empty); the FSM and output registers SHALL live in port_requester.

Verification
REQ-033 Push single flit 3_0000_00AA at edge 1, then hold gnt=1 from cycle 3 -> req=1 after edge 2, out_valid=1 with out_flit 3_0000_00AA after edge 3, req=0 in that same cycle.
REQ-034 Push head/body/body/tail (payloads 1, 2, 3, 4) with gnt=1 continuous -> four consecutive out_valid cycles in order 1, 2, 3, 4, then req falls.
REQ-035 Same 4-flit packet with gnt toggling 1,0,1,0,... -> flits appear only after gnt=1 edges, req stays 1 throughout, no flit is lost or duplicated.
REQ-036 Push 5 flits with no gnt -> in_ready=0 after the 4th push and the 5th flit is refused; one granted pop -> in_ready returns to 1 the next cycle.
REQ-037 Push a body flit first while in IDLE -> drop_err pulses once, req stays 0, and the FIFO becomes empty.
REQ-038 Assert rst mid-packet after 2 of 4 flits have been sent -> req and out_valid are 0 immediately; after release, a new single-flit packet is forwarded correctly.
